// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: shared byte type and FIFO depth for the uart buffer slice   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;
  typedef logic [7:0] byte_t;
  localparam int UART_FIFO_DEPTH = 16;
endpackage
`default_nettype wire

// File: rtl/uart_buffer_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: first-word-fall-through FIFO, head is a mux of mem[rd_ptr] |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Gate internally too so a careless parent cannot corrupt the pointers.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == c_cw'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    localparam logic [c_aw-1:0] c_idx = c_aw'(gi);
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                        r_mem[gi] <= '0;
      else if (w_push && r_wr_ptr == c_idx) r_mem[gi] <= push_data;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_buffer: TX/RX byte FIFOs between CPU registers and the uart      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_tx_valid,
  input  byte_t         cpu_tx_data,
  output logic          cpu_tx_ready,
  output logic          cpu_rx_valid,
  output byte_t         cpu_rx_data,
  input  logic          cpu_rx_ready,
  output logic          uart_tx_valid,
  output byte_t         uart_tx_data,
  input  logic          uart_tx_complete,
  input  logic          uart_rx_complete,
  input  byte_t         uart_rx_data,
  output logic [CW-1:0] tx_count,
  output logic [CW-1:0] rx_count,
  output logic          rx_overrun,
  input  logic          clear_overrun
);
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic r_rx_overrun;

  // Ready depends only on full, so a write into a full FIFO is lost even
  // when the uart pops in the same cycle.
  assign cpu_tx_ready = !w_tx_full;
  assign w_tx_push    = cpu_tx_valid && !w_tx_full;
  assign w_tx_pop     = uart_tx_complete && !w_tx_empty;
  assign uart_tx_valid = !w_tx_empty;

  assign w_rx_push    = uart_rx_complete && !w_rx_full;
  assign w_rx_pop     = cpu_rx_ready && !w_rx_empty;
  assign cpu_rx_valid = !w_rx_empty;
  assign rx_overrun   = r_rx_overrun;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_tx_push),
    .push_data (cpu_tx_data),
    .pop       (w_tx_pop),
    .head      (uart_tx_data),
    .full      (w_tx_full),
    .empty     (w_tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_rx_push),
    .push_data (uart_rx_data),
    .pop       (w_rx_pop),
    .head      (cpu_rx_data),
    .full      (w_rx_full),
    .empty     (w_rx_empty),
    .count     (rx_count)
  );

  // A drop outranks a software clear in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          r_rx_overrun <= 1'b0;
    else if (uart_rx_complete && w_rx_full) r_rx_overrun <= 1'b1;
    else if (clear_overrun)                r_rx_overrun <= 1'b0;
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_buffer: directed and randomized checks, DEPTH=16 and DEPTH=4  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_buffer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_tx_valid = 0, cpu_rx_ready = 0, uart_tx_complete = 0;
  logic       uart_rx_complete = 0, clear_overrun = 0;
  logic [7:0] cpu_tx_data = 0, uart_rx_data = 0;
  logic       cpu_tx_ready, cpu_rx_valid, uart_tx_valid, rx_overrun;
  logic [7:0] cpu_rx_data, uart_tx_data;
  logic [4:0] tx_count, rx_count;

  logic       s_cpu_tx_valid = 0, s_cpu_rx_ready = 0, s_uart_tx_complete = 0;
  logic       s_uart_rx_complete = 0, s_clear_overrun = 0;
  logic [7:0] s_cpu_tx_data = 0, s_uart_rx_data = 0;
  logic       s_cpu_tx_ready, s_cpu_rx_valid, s_uart_tx_valid, s_rx_overrun;
  logic [7:0] s_cpu_rx_data, s_uart_tx_data;
  logic [2:0] s_tx_count, s_rx_count;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  uart_buffer dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_tx_valid(cpu_tx_valid), .cpu_tx_data(cpu_tx_data), .cpu_tx_ready(cpu_tx_ready),
    .cpu_rx_valid(cpu_rx_valid), .cpu_rx_data(cpu_rx_data), .cpu_rx_ready(cpu_rx_ready),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
    .uart_tx_complete(uart_tx_complete), .uart_rx_complete(uart_rx_complete),
    .uart_rx_data(uart_rx_data), .tx_count(tx_count), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .clear_overrun(clear_overrun)
  );

  uart_buffer #(.DEPTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .cpu_tx_valid(s_cpu_tx_valid), .cpu_tx_data(s_cpu_tx_data), .cpu_tx_ready(s_cpu_tx_ready),
    .cpu_rx_valid(s_cpu_rx_valid), .cpu_rx_data(s_cpu_rx_data), .cpu_rx_ready(s_cpu_rx_ready),
    .uart_tx_valid(s_uart_tx_valid), .uart_tx_data(s_uart_tx_data),
    .uart_tx_complete(s_uart_tx_complete), .uart_rx_complete(s_uart_rx_complete),
    .uart_rx_data(s_uart_rx_data), .tx_count(s_tx_count), .rx_count(s_rx_count),
    .rx_overrun(s_rx_overrun), .clear_overrun(s_clear_overrun)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cpu_tx_valid = 1; cpu_tx_data = 8'h77;
    uart_rx_complete = 1; uart_rx_data = 8'h33;
    tick();
    cpu_tx_valid = 0; uart_rx_complete = 0;
    total++;
    if (tx_count !== 5'd1 || rx_count !== 5'd1) begin
      bad++; $display("FAIL pre_reset_counts got tx=%0d rx=%0d exp 1 1", tx_count, rx_count);
    end
    #3 reset_n = 0;
    #1;
    total++;
    if (tx_count !== 0 || rx_count !== 0 || cpu_tx_ready !== 1'b1 || uart_tx_valid !== 0 ||
        uart_tx_data !== 0 || cpu_rx_valid !== 0 || cpu_rx_data !== 0 || rx_overrun !== 0) begin
      bad++;
      $display("FAIL async_reset got tx=%0d rx=%0d rdy=%b utv=%b utd=%h crv=%b crd=%h ovr=%b exp 0 0 1 0 00 0 00 0",
               tx_count, rx_count, cpu_tx_ready, uart_tx_valid, uart_tx_data, cpu_rx_valid, cpu_rx_data, rx_overrun);
    end
    #2 reset_n = 1;
    tick();
    uart_tx_complete = 1; // complete on empty FIFO must be ignored
    tick();
    uart_tx_complete = 0;
    total++;
    if (tx_count !== 0 || uart_tx_valid !== 0 || cpu_tx_ready !== 1'b1) begin
      bad++; $display("FAIL idle_after_reset got tx=%0d utv=%b rdy=%b exp 0 0 1", tx_count, uart_tx_valid, cpu_tx_ready);
    end
  endtask

  task automatic test_tx_basic();
    logic [7:0] exp_head [3] = '{8'h42, 8'h43, 8'h00};
    for (int i = 0; i < 3; i++) begin
      cpu_tx_valid = 1; cpu_tx_data = 8'h41 + 8'(i);
      tick();
      if (i == 0) begin
        total++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
          bad++; $display("FAIL tx_first_latency got v=%b d=%h exp 1 41", uart_tx_valid, uart_tx_data);
        end
      end
    end
    cpu_tx_valid = 0;
    total++;
    if (tx_count !== 5'd3) begin
      bad++; $display("FAIL tx_count3 got %0d exp 3", tx_count);
    end
    tick();
    total++;
    if (uart_tx_data !== 8'h41) begin
      bad++; $display("FAIL tx_head_stable got %h exp 41", uart_tx_data);
    end
    for (int i = 0; i < 3; i++) begin
      uart_tx_complete = 1;
      tick();
      uart_tx_complete = 0;
      total++;
      if (i < 2 && (uart_tx_valid !== 1'b1 || uart_tx_data !== exp_head[i])) begin
        bad++; $display("FAIL tx_drain%0d got v=%b d=%h exp 1 %h", i, uart_tx_valid, uart_tx_data, exp_head[i]);
      end else if (i == 2 && uart_tx_valid !== 1'b0) begin
        bad++; $display("FAIL tx_drain_empty got v=%b exp 0", uart_tx_valid);
      end
    end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 16; i++) begin
      cpu_tx_valid = 1; cpu_tx_data = 8'(i);
      tick();
    end
    total++;
    if (tx_count !== 5'd16 || cpu_tx_ready !== 1'b0) begin
      bad++; $display("FAIL tx_full got cnt=%0d rdy=%b exp 16 0", tx_count, cpu_tx_ready);
    end
    cpu_tx_data = 8'hFF; uart_tx_complete = 1;
    tick();
    cpu_tx_valid = 0; uart_tx_complete = 0;
    total++;
    if (tx_count !== 5'd15 || cpu_tx_ready !== 1'b1) begin
      bad++; $display("FAIL tx_full_drop got cnt=%0d rdy=%b exp 15 1", tx_count, cpu_tx_ready);
    end
    for (int i = 1; i < 16; i++) begin
      total++;
      if (uart_tx_data !== 8'(i)) begin
        bad++; $display("FAIL tx_full_order got %h exp %h", uart_tx_data, 8'(i));
      end
      uart_tx_complete = 1;
      tick();
      uart_tx_complete = 0;
    end
    total++;
    if (uart_tx_valid !== 1'b0 || tx_count !== 0) begin
      bad++; $display("FAIL tx_full_empty got v=%b cnt=%0d exp 0 0", uart_tx_valid, tx_count);
    end
  endtask

  task automatic test_rx_overrun();
    for (int i = 0; i < 17; i++) begin
      uart_rx_complete = 1; uart_rx_data = (i < 16) ? 8'h10 + 8'(i) : 8'hAA;
      tick();
    end
    uart_rx_complete = 0;
    total++;
    if (rx_count !== 5'd16 || rx_overrun !== 1'b1 || cpu_rx_data !== 8'h10) begin
      bad++; $display("FAIL rx_overrun got cnt=%0d ovr=%b d=%h exp 16 1 10", rx_count, rx_overrun, cpu_rx_data);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cpu_rx_valid !== 1'b1 || cpu_rx_data !== 8'h10 + 8'(i)) begin
        bad++; $display("FAIL rx_pop%0d got v=%b d=%h exp 1 %h", i, cpu_rx_valid, cpu_rx_data, 8'h10 + 8'(i));
      end
      cpu_rx_ready = 1;
      tick();
      cpu_rx_ready = 0;
    end
    total++;
    if (cpu_rx_valid !== 1'b0 || rx_count !== 0 || rx_overrun !== 1'b1) begin
      bad++; $display("FAIL rx_after_drain got v=%b cnt=%0d ovr=%b exp 0 0 1", cpu_rx_valid, rx_count, rx_overrun);
    end
  endtask

  task automatic test_clear_overrun();
    clear_overrun = 1;
    tick();
    clear_overrun = 0;
    total++;
    if (rx_overrun !== 1'b0) begin
      bad++; $display("FAIL clear_alone got %b exp 0", rx_overrun);
    end
    for (int i = 0; i < 16; i++) begin
      uart_rx_complete = 1; uart_rx_data = 8'h20 + 8'(i);
      tick();
    end
    // Drop, pop and clear all in one cycle: byte lost, set beats clear.
    uart_rx_data = 8'hBB; cpu_rx_ready = 1; clear_overrun = 1;
    tick();
    uart_rx_complete = 0; cpu_rx_ready = 0; clear_overrun = 0;
    total++;
    if (rx_overrun !== 1'b1 || rx_count !== 5'd15 || cpu_rx_data !== 8'h21) begin
      bad++; $display("FAIL clear_vs_drop got ovr=%b cnt=%0d d=%h exp 1 15 21", rx_overrun, rx_count, cpu_rx_data);
    end
    clear_overrun = 1;
    tick();
    clear_overrun = 0;
    total++;
    if (rx_overrun !== 1'b0) begin
      bad++; $display("FAIL clear_next got %b exp 0", rx_overrun);
    end
    for (int i = 1; i < 16; i++) begin
      total++;
      if (cpu_rx_data !== 8'h20 + 8'(i)) begin
        bad++; $display("FAIL clear_drain got %h exp %h", cpu_rx_data, 8'h20 + 8'(i));
      end
      cpu_rx_ready = 1;
      tick();
      cpu_rx_ready = 0;
    end
  endtask

  task automatic test_wrap();
    int max_cnt = 0;
    for (int k = 0; k <= 10; k++) begin
      s_uart_rx_complete = (k < 10);
      s_uart_rx_data     = 8'h50 + 8'(k);
      s_cpu_rx_ready     = (k > 0);
      if (k > 0) begin
        total++;
        if (s_cpu_rx_valid !== 1'b1 || s_cpu_rx_data !== 8'h50 + 8'(k - 1)) begin
          bad++; $display("FAIL wrap_pop%0d got v=%b d=%h exp 1 %h", k - 1, s_cpu_rx_valid, s_cpu_rx_data, 8'h50 + 8'(k - 1));
        end
      end
      tick();
      if (int'(s_rx_count) > max_cnt) max_cnt = int'(s_rx_count);
    end
    s_uart_rx_complete = 0; s_cpu_rx_ready = 0;
    total++;
    if (max_cnt > 2 || s_rx_count !== 0) begin
      bad++; $display("FAIL wrap_count got max=%0d final=%0d exp <=2 0", max_cnt, s_rx_count);
    end
  endtask

  // Shared random stimulus to both instances, each tracked by a queue model.
  task automatic test_random();
    logic [7:0] txq [2][$];
    logic [7:0] rxq [2][$];
    logic       ovr [2] = '{1'b0, 1'b0};
    int         dep [2] = '{16, 4};
    logic tv, tc, rc, rr, cl;
    logic [7:0] td, rd;
    int g_tx, g_rx;
    logic g_ovr, g_utv, g_rdy;
    logic [7:0] g_utd, g_crd;
    reset_n = 0; #2 reset_n = 1;
    tick();
    for (int c = 0; c < 400; c++) begin
      tv = ($urandom_range(0, 1) == 1); tc = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 1) == 1); rr = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 7) == 0);
      td = 8'($urandom); rd = 8'($urandom);
      cpu_tx_valid = tv; cpu_tx_data = td; uart_tx_complete = tc;
      uart_rx_complete = rc; uart_rx_data = rd; cpu_rx_ready = rr; clear_overrun = cl;
      s_cpu_tx_valid = tv; s_cpu_tx_data = td; s_uart_tx_complete = tc;
      s_uart_rx_complete = rc; s_uart_rx_data = rd; s_cpu_rx_ready = rr; s_clear_overrun = cl;
      for (int d = 0; d < 2; d++) begin
        bit tx_full = (txq[d].size() == dep[d]);
        bit rx_full = (rxq[d].size() == dep[d]);
        if (tc && txq[d].size() > 0) void'(txq[d].pop_front());
        if (tv && !tx_full) txq[d].push_back(td);
        if (rr && rxq[d].size() > 0) void'(rxq[d].pop_front());
        if (rc && !rx_full) rxq[d].push_back(rd);
        if (rc && rx_full) ovr[d] = 1'b1;
        else if (cl)       ovr[d] = 1'b0;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          g_tx = int'(tx_count); g_rx = int'(rx_count); g_ovr = rx_overrun; g_utv = uart_tx_valid;
          g_rdy = cpu_tx_ready; g_utd = uart_tx_data; g_crd = cpu_rx_data;
        end else begin
          g_tx = int'(s_tx_count); g_rx = int'(s_rx_count); g_ovr = s_rx_overrun; g_utv = s_uart_tx_valid;
          g_rdy = s_cpu_tx_ready; g_utd = s_uart_tx_data; g_crd = s_cpu_rx_data;
        end
        total++;
        if (g_tx != txq[d].size() || g_rx != rxq[d].size() || g_ovr !== ovr[d] ||
            g_utv !== (txq[d].size() > 0) || g_rdy !== (txq[d].size() < dep[d])) begin
          bad++;
          $display("FAIL rnd_status d=%0d cyc=%0d got tx=%0d rx=%0d ovr=%b v=%b rdy=%b exp %0d %0d %b %b %b",
                   dep[d], c, g_tx, g_rx, g_ovr, g_utv, g_rdy, txq[d].size(), rxq[d].size(), ovr[d],
                   txq[d].size() > 0, txq[d].size() < dep[d]);
        end
        if (txq[d].size() > 0) begin
          total++;
          if (g_utd !== txq[d][0]) begin
            bad++; $display("FAIL rnd_tx_head d=%0d cyc=%0d got %h exp %h", dep[d], c, g_utd, txq[d][0]);
          end
        end
        if (rxq[d].size() > 0) begin
          total++;
          if (g_crd !== rxq[d][0]) begin
            bad++; $display("FAIL rnd_rx_head d=%0d cyc=%0d got %h exp %h", dep[d], c, g_crd, rxq[d][0]);
          end
        end
      end
    end
    cpu_tx_valid = 0; uart_tx_complete = 0; uart_rx_complete = 0; cpu_rx_ready = 0; clear_overrun = 0;
    s_cpu_tx_valid = 0; s_uart_tx_complete = 0; s_uart_rx_complete = 0; s_cpu_rx_ready = 0; s_clear_overrun = 0;
  endtask

  initial begin
    #12 reset_n = 1;
    tick();
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_overrun();
    test_clear_overrun();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
